// File: rtl/video_timing_pkg.sv
// Shared raster timing presets for video_timing_gen, plus helpers that derive
// the full line and frame lengths from a preset.
package video_timing_pkg;

  typedef struct packed {
    int h_display;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_display;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } timing_t;

  localparam timing_t VGA_640x480_60 = '{
    h_display: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_display: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam timing_t SVGA_800x600_60 = '{
    h_display: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_display: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  function automatic int h_total(timing_t t);
    return t.h_display + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic int v_total(timing_t t);
    return t.v_display + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// Pixel-enable divider: raises adv on the last clk of every CLK_DIV-cycle
// group while run is high; the phase holds while run is low.
module pixel_ce_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic adv
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign adv = run && (div_cnt == LAST);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: position counters, sync/blank decode
// and line/frame/vblank strobes, all registered from the next-position values.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_640x480_60.h_display,
  parameter int H_FP      = VGA_640x480_60.h_fp,
  parameter int H_SYNC    = VGA_640x480_60.h_sync,
  parameter int H_BP      = VGA_640x480_60.h_bp,
  parameter int V_DISPLAY = VGA_640x480_60.v_display,
  parameter int V_FP      = VGA_640x480_60.v_fp,
  parameter int V_SYNC    = VGA_640x480_60.v_sync,
  parameter int V_BP      = VGA_640x480_60.v_bp,
  parameter bit HS_POL    = VGA_640x480_60.hs_pol,
  parameter bit VS_POL    = VGA_640x480_60.vs_pol,
  parameter int CLK_DIV   = 1,
  parameter int CNT_W     = 10,
  parameter int FRM_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic [CNT_W-1:0] hpos,
  output logic [CNT_W-1:0] vpos,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start,
  output logic [FRM_W-1:0] frame_count
);

  localparam timing_t CFG = '{
    h_display: H_DISPLAY, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_display: V_DISPLAY, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
    hs_pol: HS_POL, vs_pol: VS_POL
  };
  localparam int H_TOTAL   = h_total(CFG);
  localparam int V_TOTAL   = v_total(CFG);
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("video_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("video_timing_gen: porch and sync widths must be non-zero");
  end
  if ((longint'(1) << CNT_W) < longint'(MAX_TOTAL)) begin : g_bad_width
    $error("video_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  // Window bounds; the sync end is always below the total because back porch > 0.
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISPLAY + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISPLAY + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISPLAY + V_FP + V_SYNC);

  logic             adv;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             hs_act;
  logic             vs_act;
  logic             act_next;
  logic             origin_next;

  pixel_ce_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .adv  (adv)
  );

  // Decode is done on the next position so every output lands with its pixel.
  always_comb begin
    h_wrap      = (hpos == H_LAST);
    v_wrap      = h_wrap && (vpos == V_LAST);
    h_next      = h_wrap ? '0 : hpos + CNT_W'(1);
    v_next      = vpos;
    if (h_wrap) begin
      v_next = (vpos == V_LAST) ? '0 : vpos + CNT_W'(1);
    end
    hs_act      = (h_next >= HS_BEG) && (h_next < HS_END);
    vs_act      = (v_next >= VS_BEG) && (v_next < VS_END);
    act_next    = (h_next < H_ACT) && (v_next < V_ACT);
    origin_next = (h_next == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_ce       <= 1'b0;
      hpos         <= '0;
      vpos         <= '0;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      display_on   <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      pix_ce       <= adv;
      line_start   <= adv && origin_next;
      frame_start  <= adv && origin_next && (v_next == '0);
      vblank_start <= adv && origin_next && (v_next == V_ACT);
      if (adv) begin
        hpos       <= h_next;
        vpos       <= v_next;
        hsync      <= hs_act ? HS_POL : ~HS_POL;
        vsync      <= vs_act ? VS_POL : ~VS_POL;
        display_on <= act_next;
        if (v_wrap) begin
          frame_count <= frame_count + FRM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a VGA-default instance and a small-raster
// instance with CLK_DIV=3 and active-high syncs, both checked against a
// pixel-count arithmetic model.
`timescale 1ns/1ps
module tb_video_timing_gen;

  typedef struct packed {
    int hd; int hfp; int hs; int hbp;
    int vd; int vfp; int vs; int vbp;
    bit hpol; bit vpol;
  } cfg_t;

  typedef struct packed {
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [7:0] frame_count;
  } vout_t;

  localparam cfg_t VGA_CFG = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t SML_CFG = '{16, 2, 3, 4, 12, 2, 2, 3, 1'b1, 1'b1};
  localparam int VGA_DIV = 1;
  localparam int SML_DIV = 3;
  localparam int SML_HT  = 25;
  localparam int SML_VT  = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic vga_reset = 1'b1, vga_run = 1'b0, sml_reset = 1'b1, sml_run = 1'b0;
  logic vga_pix_ce, vga_hsync, vga_vsync, vga_display_on;
  logic vga_line_start, vga_frame_start, vga_vblank_start;
  logic [9:0] vga_hpos, vga_vpos;
  logic [7:0] vga_frame_count;
  logic sml_pix_ce, sml_hsync, sml_vsync, sml_display_on;
  logic sml_line_start, sml_frame_start, sml_vblank_start;
  logic [9:0] sml_hpos, sml_vpos;
  logic [7:0] sml_frame_count;
  vout_t vga_obs, sml_obs;

  int checks = 0;
  int failures = 0;
  int vga_rc = 0, vga_pix = 0, sml_rc = 0, sml_pix = 0;
  bit vga_adv = 1'b0, sml_adv = 1'b0;

  video_timing_gen u_vga (
    .clk(clk), .reset(vga_reset), .run(vga_run),
    .pix_ce(vga_pix_ce), .hsync(vga_hsync), .vsync(vga_vsync),
    .display_on(vga_display_on), .hpos(vga_hpos), .vpos(vga_vpos),
    .line_start(vga_line_start), .frame_start(vga_frame_start),
    .vblank_start(vga_vblank_start), .frame_count(vga_frame_count)
  );

  video_timing_gen #(
    .H_DISPLAY(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_DISPLAY(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(SML_DIV), .CNT_W(10), .FRM_W(8)
  ) u_sml (
    .clk(clk), .reset(sml_reset), .run(sml_run),
    .pix_ce(sml_pix_ce), .hsync(sml_hsync), .vsync(sml_vsync),
    .display_on(sml_display_on), .hpos(sml_hpos), .vpos(sml_vpos),
    .line_start(sml_line_start), .frame_start(sml_frame_start),
    .vblank_start(sml_vblank_start), .frame_count(sml_frame_count)
  );

  assign vga_obs = {vga_pix_ce, vga_hsync, vga_vsync, vga_display_on, vga_line_start,
                    vga_frame_start, vga_vblank_start, vga_hpos, vga_vpos, vga_frame_count};
  assign sml_obs = {sml_pix_ce, sml_hsync, sml_vsync, sml_display_on, sml_line_start,
                    sml_frame_start, sml_vblank_start, sml_hpos, sml_vpos, sml_frame_count};

  // Expected outputs after `pix` pixel advances since reset; adv marks a fresh pixel.
  function automatic vout_t model(cfg_t c, int pix, bit adv);
    vout_t e;
    int ht, vt, frame, pos, h, v;
    ht = c.hd + c.hfp + c.hs + c.hbp;
    vt = c.vd + c.vfp + c.vs + c.vbp;
    e = '0;
    e.hsync = ~c.hpol;
    e.vsync = ~c.vpol;
    if (pix > 0) begin
      frame = ht * vt;
      pos = pix % frame;
      h = pos % ht;
      v = pos / ht;
      e.pix_ce = adv;
      e.hpos = 10'(h);
      e.vpos = 10'(v);
      if (h >= c.hd + c.hfp && h < c.hd + c.hfp + c.hs) e.hsync = c.hpol;
      if (v >= c.vd + c.vfp && v < c.vd + c.vfp + c.vs) e.vsync = c.vpol;
      e.display_on = (h < c.hd) && (v < c.vd);
      e.line_start = adv && (h == 0);
      e.frame_start = adv && (pos == 0);
      e.vblank_start = adv && (h == 0) && (v == c.vd);
      e.frame_count = 8'(pix / frame);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (vga_reset) begin
      vga_rc = 0; vga_pix = 0; vga_adv = 1'b0;
    end else begin
      vga_adv = 1'b0;
      if (vga_run) begin
        vga_rc++;
        vga_adv = (vga_rc % VGA_DIV) == 0;
        if (vga_adv) vga_pix++;
      end
    end
    if (sml_reset) begin
      sml_rc = 0; sml_pix = 0; sml_adv = 1'b0;
    end else begin
      sml_adv = 1'b0;
      if (sml_run) begin
        sml_rc++;
        sml_adv = (sml_rc % SML_DIV) == 0;
        if (sml_adv) sml_pix++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    vga_reset = 1'b1; sml_reset = 1'b1; vga_run = 1'b1; sml_run = 1'b1;
    repeat (3) tick();
    checks++; if (vga_hpos !== 10'd0 || vga_vpos !== 10'd0) begin failures++; $display("[TB] FAIL reset_vga_pos: got (%0d,%0d) expected (0,0)", vga_hpos, vga_vpos); end
    checks++; if ({vga_hsync, vga_vsync} !== 2'b11) begin failures++; $display("[TB] FAIL reset_vga_sync: got %b expected 11", {vga_hsync, vga_vsync}); end
    checks++; if ({sml_hsync, sml_vsync} !== 2'b00) begin failures++; $display("[TB] FAIL reset_sml_sync: got %b expected 00", {sml_hsync, sml_vsync}); end
    checks++; if ({vga_pix_ce, vga_display_on, vga_line_start, vga_frame_start, vga_vblank_start} !== 5'b0) begin failures++; $display("[TB] FAIL reset_vga_flags: got %b expected 00000", {vga_pix_ce, vga_display_on, vga_line_start, vga_frame_start, vga_vblank_start}); end
    checks++; if (vga_frame_count !== 8'd0 || sml_frame_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_frame_count: got %0d/%0d expected 0/0", vga_frame_count, sml_frame_count); end
    vga_reset = 1'b0; sml_reset = 1'b0;
    tick();
    checks++; if (vga_hpos !== 10'd1 || vga_pix_ce !== 1'b1) begin failures++; $display("[TB] FAIL first_adv_vga: got hpos=%0d pix_ce=%b expected hpos=1 pix_ce=1", vga_hpos, vga_pix_ce); end
    checks++; if ({vga_line_start, vga_frame_start} !== 2'b00) begin failures++; $display("[TB] FAIL no_strobe_from_reset: got %b expected 00", {vga_line_start, vga_frame_start}); end
    checks++; if (sml_pix_ce !== 1'b0 || sml_hpos !== 10'd0) begin failures++; $display("[TB] FAIL sml_div_wait: got pix_ce=%b hpos=%0d expected 0/0", sml_pix_ce, sml_hpos); end
    repeat (2) tick();
    checks++; if (sml_pix_ce !== 1'b1 || sml_hpos !== 10'd1) begin failures++; $display("[TB] FAIL sml_first_adv: got pix_ce=%b hpos=%0d expected 1/1", sml_pix_ce, sml_hpos); end
  endtask

  task automatic test_vga_lines();
    int cnt = 0, lo = 9999, hi = -1;
    bit done = 1'b0;
    logic [9:0] prev_h, prev_v;
    vga_run = 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      prev_h = vga_hpos; prev_v = vga_vpos;
      tick();
      checks++; if (vga_obs !== model(VGA_CFG, vga_pix, vga_adv)) begin failures++; $display("[TB] FAIL vga_lines_model: got %p expected %p", vga_obs, model(VGA_CFG, vga_pix, vga_adv)); end
      if (prev_h == 10'd799) begin
        checks++; if (vga_hpos !== 10'd0 || vga_vpos !== prev_v + 10'd1) begin failures++; $display("[TB] FAIL hpos_wrap: got (%0d,%0d) expected (0,%0d)", vga_hpos, vga_vpos, prev_v + 10'd1); end
      end
      if (vga_pix_ce && vga_vpos == 10'd1 && vga_hsync == 1'b0) begin
        cnt++;
        if (int'(vga_hpos) < lo) lo = int'(vga_hpos);
        if (int'(vga_hpos) > hi) hi = int'(vga_hpos);
      end
      if (vga_vpos == 10'd2) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("[TB] FAIL vga_lines_timeout: got vpos=%0d expected 2", vga_vpos); end
    checks++; if (cnt !== 96 || lo !== 656 || hi !== 751) begin failures++; $display("[TB] FAIL hsync_window: got %0d px %0d..%0d expected 96 px 656..751", cnt, lo, hi); end
  endtask

  task automatic test_pause();
    bit found = 1'b0;
    vga_run = 1'b1;
    for (int t = 0; t < 6000 && !found; t++) begin
      tick();
      if (vga_pix_ce && vga_hpos == 10'd100 && vga_vpos == 10'd5) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL pause_reach: got (%0d,%0d) expected (100,5)", vga_hpos, vga_vpos); end
    if (found) begin
      vga_run = 1'b0;
      for (int t = 0; t < 37; t++) begin
        tick();
        checks++; if (vga_obs !== model(VGA_CFG, vga_pix, vga_adv) || vga_pix_ce !== 1'b0 || vga_hpos !== 10'd100) begin failures++; $display("[TB] FAIL pause_hold: got %p expected %p", vga_obs, model(VGA_CFG, vga_pix, vga_adv)); end
      end
      vga_run = 1'b1;
      tick();
      checks++; if (vga_hpos !== 10'd101 || vga_vpos !== 10'd5 || vga_pix_ce !== 1'b1) begin failures++; $display("[TB] FAIL pause_resume: got (%0d,%0d) pix_ce=%b expected (101,5) pix_ce=1", vga_hpos, vga_vpos, vga_pix_ce); end
    end
  endtask

  task automatic test_divider();
    int pc = 0, first_ls = -1, second_ls = -1, bad_moves = 0;
    logic [9:0] prev_h;
    sml_reset = 1'b1; sml_run = 1'b1;
    tick();
    sml_reset = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      prev_h = sml_hpos;
      tick();
      checks++; if (sml_obs !== model(SML_CFG, sml_pix, sml_adv)) begin failures++; $display("[TB] FAIL div_model: got %p expected %p", sml_obs, model(SML_CFG, sml_pix, sml_adv)); end
      if (t <= 150 && sml_pix_ce) pc++;
      if (sml_hpos != prev_h && !sml_pix_ce) bad_moves++;
      if (sml_line_start) begin
        if (first_ls < 0) first_ls = t;
        else if (second_ls < 0) second_ls = t;
      end
    end
    checks++; if (pc !== 50) begin failures++; $display("[TB] FAIL div_pix_ce_rate: got %0d expected 50", pc); end
    checks++; if (bad_moves !== 0) begin failures++; $display("[TB] FAIL div_hpos_moves: got %0d expected 0", bad_moves); end
    checks++; if (second_ls - first_ls !== SML_HT * SML_DIV) begin failures++; $display("[TB] FAIL div_line_len: got %0d expected %0d", second_ls - first_ls, SML_HT * SML_DIV); end
  endtask

  task automatic test_frames();
    int pc = 0, ls = 0, fs = 0, vb = 0, don = 0, vb_bad = 0;
    sml_reset = 1'b1; sml_run = 1'b1;
    tick();
    sml_reset = 1'b0;
    for (int t = 0; t < 4000 && pc < 2 * SML_HT * SML_VT; t++) begin
      tick();
      checks++; if (sml_obs !== model(SML_CFG, sml_pix, sml_adv)) begin failures++; $display("[TB] FAIL frames_model: got %p expected %p", sml_obs, model(SML_CFG, sml_pix, sml_adv)); end
      if (sml_pix_ce) begin
        pc++;
        if (pc <= SML_HT * SML_VT) begin
          ls += int'(sml_line_start);
          fs += int'(sml_frame_start);
          vb += int'(sml_vblank_start);
          don += int'(sml_display_on);
          if (sml_vblank_start && (sml_hpos != 10'd0 || sml_vpos != 10'd12)) vb_bad++;
        end
      end
    end
    checks++; if (ls !== SML_VT || fs !== 1 || vb !== 1) begin failures++; $display("[TB] FAIL frame_strobes: got ls=%0d fs=%0d vb=%0d expected %0d/1/1", ls, fs, vb, SML_VT); end
    checks++; if (vb_bad !== 0) begin failures++; $display("[TB] FAIL vblank_pos: got %0d misplaced expected 0", vb_bad); end
    checks++; if (don !== 16 * 12) begin failures++; $display("[TB] FAIL display_on_count: got %0d expected %0d", don, 16 * 12); end
    checks++; if (sml_frame_count !== 8'd2 || pc !== 2 * SML_HT * SML_VT) begin failures++; $display("[TB] FAIL frame_count: got %0d after %0d pix_ce expected 2 after %0d", sml_frame_count, pc, 2 * SML_HT * SML_VT); end
  endtask

  task automatic test_random_run();
    for (int t = 0; t < 3000; t++) begin
      vga_run = ($urandom_range(0, 3) != 0);
      sml_run = ($urandom_range(0, 4) != 0);
      sml_reset = ($urandom_range(0, 399) == 0);
      tick();
      checks++; if (vga_obs !== model(VGA_CFG, vga_pix, vga_adv)) begin failures++; $display("[TB] FAIL random_vga: got %p expected %p", vga_obs, model(VGA_CFG, vga_pix, vga_adv)); end
      checks++; if (sml_obs !== model(SML_CFG, sml_pix, sml_adv)) begin failures++; $display("[TB] FAIL random_sml: got %p expected %p", sml_obs, model(SML_CFG, sml_pix, sml_adv)); end
    end
    sml_reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0, seen = 1'b0;
    int pc = 0, first_pc = -1;
    sml_reset = 1'b1; sml_run = 1'b1;
    tick();
    sml_reset = 1'b0;
    for (int t = 0; t < 1500 && !found; t++) begin
      tick();
      if (sml_pix_ce && sml_hpos == 10'd7 && sml_vpos == 10'd9) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("[TB] FAIL mid_reach: got (%0d,%0d) expected (7,9)", sml_hpos, sml_vpos); end
    tick();
    sml_reset = 1'b1;
    #1;
    checks++; if (sml_hpos !== 10'd0 || sml_vpos !== 10'd0 || {sml_hsync, sml_vsync} !== 2'b00) begin failures++; $display("[TB] FAIL mid_async_reset: got (%0d,%0d) sync=%b expected (0,0) sync=00", sml_hpos, sml_vpos, {sml_hsync, sml_vsync}); end
    tick();
    checks++; if (sml_obs !== model(SML_CFG, 0, 1'b0) || sml_pix_ce !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_values: got %p expected %p", sml_obs, model(SML_CFG, 0, 1'b0)); end
    sml_reset = 1'b0;
    for (int t = 1; t <= 2000 && !seen; t++) begin
      tick();
      if (sml_pix_ce) begin
        pc++;
        if (first_pc < 0) first_pc = t;
      end
      if (sml_frame_start) seen = 1'b1;
    end
    checks++; if (first_pc !== SML_DIV) begin failures++; $display("[TB] FAIL mid_div_phase: got first pix_ce at %0d expected %0d", first_pc, SML_DIV); end
    checks++; if (!seen || pc !== SML_HT * SML_VT) begin failures++; $display("[TB] FAIL mid_first_frame: got %0d pix_ce seen=%b expected %0d", pc, seen, SML_HT * SML_VT); end
  endtask

  initial begin
    test_reset();
    test_vga_lines();
    test_pause();
    test_divider();
    test_frames();
    test_random_run();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
